// File: rtl/uart_spi_cmd_ctrl.sv
// Frame sequencer: rx bytes 'w' A D / 'r' A / 'x' -> SPI transfer, tx reply or timed reset pulse.
// Latency: last frame byte -> o_spi_start 2 clks; i_spi_done -> o_tx_dv 2 clks; bad byte -> o_tx_dv 2 clks.
// No backpressure on rx: bytes arriving while busy are dropped and flagged on o_overrun. CMD_TIMEOUT_EN adds the inter-byte timeout.
module uart_spi_cmd_ctrl #(
    parameter int unsigned RESET_PULSE_CLKS = 5000000,
    parameter int unsigned TIMEOUT_CLKS     = 500000,
    parameter logic [7:0]  ACK_BYTE         = 8'h4B,
    parameter logic [7:0]  ERR_BYTE         = 8'h45
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_rx_dv,
    input  logic [7:0] i_rx_byte,
    output logic       o_spi_start,
    output logic [7:0] o_spi_addr,
    output logic [7:0] o_spi_data,
    input  logic       i_spi_done,
    input  logic [7:0] i_spi_rx_byte,
    output logic       o_tx_dv,
    output logic [7:0] o_tx_byte,
    input  logic       i_tx_done,
    output logic       o_reset_pulse,
    output logic       o_busy,
    output logic       o_overrun
);

    localparam int RST_W = $clog2(RESET_PULSE_CLKS + 1);
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RESET_PULSE_CLKS - 1);

    typedef enum logic [2:0] {
        IDLE, GET_ADDR, GET_DATA, SPI_START, SPI_WAIT, TX_SEND, TX_WAIT, RST_PULSE
    } state_t;

    state_t           r_state, w_state;
    logic             r_is_read, w_is_read;
    logic [7:0]       r_spi_addr, w_spi_addr;
    logic [7:0]       r_spi_data, w_spi_data;
    logic             r_spi_start, w_spi_start;
    logic             r_tx_dv, w_tx_dv;
    logic [7:0]       r_tx_byte, w_tx_byte;
    logic [7:0]       r_resp, w_resp;
    logic             r_reset_pulse, w_reset_pulse;
    logic [RST_W-1:0] r_rst_cnt, w_rst_cnt;
    logic             r_overrun, w_overrun;
    logic             w_timeout;

`ifdef CMD_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CLKS - 1);

    logic [TMR_W-1:0] r_timer, w_timer;

    assign w_timeout = (r_timer == TMR_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state       = r_state;
        w_is_read     = r_is_read;
        w_spi_addr    = r_spi_addr;
        w_spi_data    = r_spi_data;
        w_spi_start   = 1'b0;
        w_tx_dv       = 1'b0;
        w_tx_byte     = r_tx_byte;
        w_resp        = r_resp;
        w_reset_pulse = r_reset_pulse;
        w_rst_cnt     = r_rst_cnt;
        w_overrun     = 1'b0;
`ifdef CMD_TIMEOUT_EN
        // Only the waiting-for-byte states let the timer run; everywhere else it sits at zero.
        w_timer       = '0;
`endif
        case (r_state)
            IDLE: begin
                if (i_rx_dv) begin
                    if (i_rx_byte == 8'h77 || i_rx_byte == 8'h72) begin
                        w_is_read = (i_rx_byte == 8'h72);
                        w_state   = GET_ADDR;
                    end else if (i_rx_byte == 8'h78) begin
                        w_reset_pulse = 1'b1;
                        w_rst_cnt     = '0;
                        w_state       = RST_PULSE;
                    end else begin
                        w_resp  = ERR_BYTE;
                        w_state = TX_SEND;
                    end
                end
            end
            GET_ADDR: begin
                if (i_rx_dv) begin
                    w_spi_addr = {r_is_read, i_rx_byte[6:0]};
                    if (r_is_read) begin
                        w_spi_data = 8'h00;
                        w_state    = SPI_START;
                    end else begin
                        w_state = GET_DATA;
                    end
                end else if (w_timeout) begin
                    w_resp  = ERR_BYTE;
                    w_state = TX_SEND;
                end else begin
`ifdef CMD_TIMEOUT_EN
                    w_timer = r_timer + 1'b1;
`endif
                end
            end
            GET_DATA: begin
                if (i_rx_dv) begin
                    w_spi_data = i_rx_byte;
                    w_state    = SPI_START;
                end else if (w_timeout) begin
                    w_resp  = ERR_BYTE;
                    w_state = TX_SEND;
                end else begin
`ifdef CMD_TIMEOUT_EN
                    w_timer = r_timer + 1'b1;
`endif
                end
            end
            SPI_START: begin
                w_spi_start = 1'b1;
                w_state     = SPI_WAIT;
            end
            SPI_WAIT: begin
                if (i_spi_done) begin
                    w_resp  = r_is_read ? i_spi_rx_byte : ACK_BYTE;
                    w_state = TX_SEND;
                end
            end
            TX_SEND: begin
                w_tx_byte = r_resp;
                w_tx_dv   = 1'b1;
                w_state   = TX_WAIT;
            end
            TX_WAIT: begin
                if (i_tx_done) begin
                    w_state = IDLE;
                end
            end
            RST_PULSE: begin
                if (r_rst_cnt == RST_LAST) begin
                    w_reset_pulse = 1'b0;
                    w_state       = IDLE;
                end else begin
                    w_rst_cnt = r_rst_cnt + 1'b1;
                end
            end
            default: w_state = IDLE;
        endcase

        if (i_rx_dv && !(r_state inside {IDLE, GET_ADDR, GET_DATA})) begin
            w_overrun = 1'b1;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= IDLE;
            r_is_read     <= 1'b0;
            r_spi_addr    <= 8'h00;
            r_spi_data    <= 8'h00;
            r_spi_start   <= 1'b0;
            r_tx_dv       <= 1'b0;
            r_tx_byte     <= 8'h00;
            r_resp        <= 8'h00;
            r_reset_pulse <= 1'b0;
            r_rst_cnt     <= '0;
            r_overrun     <= 1'b0;
`ifdef CMD_TIMEOUT_EN
            r_timer       <= '0;
`endif
        end else begin
            r_state       <= w_state;
            r_is_read     <= w_is_read;
            r_spi_addr    <= w_spi_addr;
            r_spi_data    <= w_spi_data;
            r_spi_start   <= w_spi_start;
            r_tx_dv       <= w_tx_dv;
            r_tx_byte     <= w_tx_byte;
            r_resp        <= w_resp;
            r_reset_pulse <= w_reset_pulse;
            r_rst_cnt     <= w_rst_cnt;
            r_overrun     <= w_overrun;
`ifdef CMD_TIMEOUT_EN
            r_timer       <= w_timer;
`endif
        end
    end

    assign o_spi_start   = r_spi_start;
    assign o_spi_addr    = r_spi_addr;
    assign o_spi_data    = r_spi_data;
    assign o_tx_dv       = r_tx_dv;
    assign o_tx_byte     = r_tx_byte;
    assign o_reset_pulse = r_reset_pulse;
    assign o_busy        = (r_state != IDLE);
    assign o_overrun     = r_overrun;

endmodule

// File: tb/tb_uart_spi_cmd_ctrl.sv
// Directed bench for uart_spi_cmd_ctrl: table of read/write frames plus hand-written reset, error, overrun and timeout sequences.
module tb_uart_spi_cmd_ctrl;

    logic       i_clock = 1'b0;
    logic       i_reset;
    logic       i_rx_dv;
    logic [7:0] i_rx_byte;
    logic       o_spi_start;
    logic [7:0] o_spi_addr;
    logic [7:0] o_spi_data;
    logic       i_spi_done;
    logic [7:0] i_spi_rx_byte;
    logic       o_tx_dv;
    logic [7:0] o_tx_byte;
    logic       i_tx_done;
    logic       o_reset_pulse;
    logic       o_busy;
    logic       o_overrun;

    int n_tests = 0;
    int n_fail  = 0;

    uart_spi_cmd_ctrl #(
        .RESET_PULSE_CLKS(20),
        .TIMEOUT_CLKS    (50),
        .ACK_BYTE        (8'h4B),
        .ERR_BYTE        (8'h45)
    ) dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_rx_dv      (i_rx_dv),
        .i_rx_byte    (i_rx_byte),
        .o_spi_start  (o_spi_start),
        .o_spi_addr   (o_spi_addr),
        .o_spi_data   (o_spi_data),
        .i_spi_done   (i_spi_done),
        .i_spi_rx_byte(i_spi_rx_byte),
        .o_tx_dv      (o_tx_dv),
        .o_tx_byte    (o_tx_byte),
        .i_tx_done    (i_tx_done),
        .o_reset_pulse(o_reset_pulse),
        .o_busy       (o_busy),
        .o_overrun    (o_overrun)
    );

    always #5 i_clock = ~i_clock;

    typedef struct {
        string      name;
        logic       is_read;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] spi_rx;
        logic [7:0] exp_addr;
        logic [7:0] exp_data;
        logic [7:0] exp_tx;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge i_clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_byte = b;
        i_rx_dv   = 1'b1;
        tick();
        i_rx_dv   = 1'b0;
    endtask

    // Called right after the final frame byte has been sampled.
    task automatic expect_spi_start(input string nm, input logic [7:0] ea, input logic [7:0] ed);
        tick();
        check({nm, " spi_start"}, 32'(o_spi_start), 32'd1);
        check({nm, " spi_addr"}, 32'(o_spi_addr), 32'(ea));
        check({nm, " spi_data"}, 32'(o_spi_data), 32'(ed));
        tick();
        check({nm, " spi_start one cycle"}, 32'(o_spi_start), 32'd0);
    endtask

    task automatic finish_txn(input string nm, input logic [7:0] ea, input logic [7:0] spi_rx,
                              input logic [7:0] etx);
        tick();
        check({nm, " addr held in wait"}, 32'(o_spi_addr), 32'(ea));
        i_spi_rx_byte = spi_rx;
        i_spi_done    = 1'b1;
        tick();
        i_spi_done    = 1'b0;
        i_spi_rx_byte = 8'h00;
        tick();
        check({nm, " tx_dv"}, 32'(o_tx_dv), 32'd1);
        check({nm, " tx_byte"}, 32'(o_tx_byte), 32'(etx));
        tick();
        check({nm, " tx_dv one cycle"}, 32'(o_tx_dv), 32'd0);
        check({nm, " busy in tx_wait"}, 32'(o_busy), 32'd1);
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
        check({nm, " idle after tx_done"}, 32'(o_busy), 32'd0);
    endtask

    initial begin
        logic       seen_tx;
        logic       seen_spi;
        logic [7:0] tx_b;
        int         pulse_cnt;

        vecs[0] = '{"wr 09<-32",    1'b0, 8'h09, 8'h32, 8'h00, 8'h09, 8'h32, 8'h4B};
        vecs[1] = '{"rd 09",        1'b1, 8'h09, 8'h00, 8'h32, 8'h89, 8'h00, 8'h32};
        vecs[2] = '{"rd F8",        1'b1, 8'hF8, 8'h00, 8'hA5, 8'hF8, 8'h00, 8'hA5};
        vecs[3] = '{"wr F8<-AA",    1'b0, 8'hF8, 8'hAA, 8'h00, 8'h78, 8'hAA, 8'h4B};

        i_reset       = 1'b1;
        i_rx_dv       = 1'b0;
        i_rx_byte     = 8'h00;
        i_spi_done    = 1'b0;
        i_spi_rx_byte = 8'h00;
        i_tx_done     = 1'b0;
        tick();
        tick();
        check("reset spi_start", 32'(o_spi_start), 32'd0);
        check("reset spi_addr", 32'(o_spi_addr), 32'd0);
        check("reset spi_data", 32'(o_spi_data), 32'd0);
        check("reset tx_dv", 32'(o_tx_dv), 32'd0);
        check("reset tx_byte", 32'(o_tx_byte), 32'd0);
        check("reset pulse", 32'(o_reset_pulse), 32'd0);
        check("reset busy", 32'(o_busy), 32'd0);
        check("reset overrun", 32'(o_overrun), 32'd0);
        i_reset = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) begin
            send_byte(vecs[i].is_read ? 8'h72 : 8'h77);
            check({vecs[i].name, " busy after opcode"}, 32'(o_busy), 32'd1);
            for (int g = 0; g < i; g++) tick();
            send_byte(vecs[i].addr);
            if (!vecs[i].is_read) begin
                for (int g = 0; g < i; g++) tick();
                send_byte(vecs[i].data);
            end
            expect_spi_start(vecs[i].name, vecs[i].exp_addr, vecs[i].exp_data);
            finish_txn(vecs[i].name, vecs[i].exp_addr, vecs[i].spi_rx, vecs[i].exp_tx);
            tick();
        end

        // Bad opcode: error byte two cycles after the strobe.
        send_byte(8'h41);
        tick();
        check("err tx_dv", 32'(o_tx_dv), 32'd1);
        check("err tx_byte", 32'(o_tx_byte), 32'h45);
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
        check("err idle", 32'(o_busy), 32'd0);

        // Reset pulse with a dropped byte in the middle.
        send_byte(8'h78);
        pulse_cnt = 0;
        seen_tx   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (o_reset_pulse) pulse_cnt++;
            if (o_tx_dv) seen_tx = 1'b1;
            if (i == 5) begin
                i_rx_byte = 8'h77;
                i_rx_dv   = 1'b1;
            end
            if (i == 6) begin
                i_rx_dv = 1'b0;
                check("pulse overrun", 32'(o_overrun), 32'd1);
            end
            if (i == 7) check("pulse overrun one cycle", 32'(o_overrun), 32'd0);
            tick();
        end
        check("pulse length", 32'(pulse_cnt), 32'd20);
        check("pulse no tx", 32'(seen_tx), 32'd0);
        check("pulse idle after", 32'(o_busy), 32'd0);

`ifdef CMD_TIMEOUT_EN
        send_byte(8'h77);
        seen_tx  = 1'b0;
        seen_spi = 1'b0;
        tx_b     = 8'h00;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (o_tx_dv) begin
                seen_tx = 1'b1;
                tx_b    = o_tx_byte;
            end
            if (o_spi_start) seen_spi = 1'b1;
        end
        check("timeout tx seen", 32'(seen_tx), 32'd1);
        check("timeout tx byte", 32'(tx_b), 32'h45);
        check("timeout no spi", 32'(seen_spi), 32'd0);
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
        check("timeout idle", 32'(o_busy), 32'd0);

        send_byte(8'h77);
        seen_tx = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (o_tx_dv) seen_tx = 1'b1;
        end
        send_byte(8'h09);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (o_tx_dv) seen_tx = 1'b1;
        end
        check("gap40 no timeout", 32'(seen_tx), 32'd0);
        check("gap40 still busy", 32'(o_busy), 32'd1);
        send_byte(8'h32);
        expect_spi_start("gap40", 8'h09, 8'h32);
        finish_txn("gap40", 8'h09, 8'h00, 8'h4B);
`else
        send_byte(8'h77);
        seen_tx = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (o_tx_dv) seen_tx = 1'b1;
        end
        check("no-timeout build no tx", 32'(seen_tx), 32'd0);
        check("no-timeout build waits", 32'(o_busy), 32'd1);
        send_byte(8'h09);
        send_byte(8'h32);
        expect_spi_start("late frame", 8'h09, 8'h32);
        finish_txn("late frame", 8'h09, 8'h00, 8'h4B);
`endif

        // Reset in the middle of SPI_WAIT abandons the transfer.
        send_byte(8'h77);
        send_byte(8'h09);
        send_byte(8'h32);
        expect_spi_start("abort", 8'h09, 8'h32);
        tick();
        i_reset = 1'b1;
        #1;
        check("abort busy", 32'(o_busy), 32'd0);
        check("abort spi_addr", 32'(o_spi_addr), 32'd0);
        check("abort spi_data", 32'(o_spi_data), 32'd0);
        tick();
        i_reset = 1'b0;
        tick();
        i_spi_rx_byte = 8'h99;
        i_spi_done    = 1'b1;
        tick();
        i_spi_done    = 1'b0;
        seen_tx = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (o_tx_dv) seen_tx = 1'b1;
        end
        check("abort late done no tx", 32'(seen_tx), 32'd0);
        check("abort late done idle", 32'(o_busy), 32'd0);
        send_byte(8'h72);
        send_byte(8'h09);
        expect_spi_start("post-abort rd", 8'h89, 8'h00);
        finish_txn("post-abort rd", 8'h89, 8'h5A, 8'h5A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
